// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
// Holds the FSM state encoding, the port-index constants and the
// default data-memory size.
package dmem_arb_pkg;

   // Default data memory size in bytes
   localparam int unsigned MEM_BYTES_DEF = 32'd32;

   // Port indices: port 0 is the CPU, port 1 is the DMA engine
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // FSM state encoding (plain constants for legacy tool compatibility)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_RESP   = 2'd2;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: tie-break for the two requesters.
// A lone request always wins. On a tie the port that was NOT granted last
// wins; tying last_grant_i to PORT1 turns this into fixed port-0 priority.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic grant_o
);

   // Select the winning port index from the current requests
   always_comb begin
      grant_o = PORT0;
      if (req0_i && req1_i) begin
         if (last_grant_i == PORT1) begin
            grant_o = PORT0;
         end else begin
            grant_o = PORT1;
         end
      end else if (req1_i) begin
         grant_o = PORT1;
      end else begin
         grant_o = PORT0;
      end
   end

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / DMA) arbiter in front of a single-port
// word-wide data memory. Each access takes IDLE -> ACCESS -> RESP, so a
// request sampled in IDLE is acknowledged two cycles later.
// Optional build macro: DMEM_ARB_RR_EN -- when defined, ties alternate
// between ports (port 0 first after reset); otherwise port 0 always wins.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
   parameter int unsigned AW        = 32'd32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_i,
   input  logic          req1_i,
   input  logic          we0_i,
   input  logic          we1_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [31:0]   wdata0_i,
   input  logic [31:0]   wdata1_i,
   output logic          ack0_o,
   output logic          ack1_o,
   output logic          err0_o,
   output logic          err1_o,
   output logic [31:0]   rdata_o,
   output logic [31:0]   mem_addr_o,
   output logic [31:0]   mem_data_o,
   output logic          mem_read_o,
   output logic          mem_write_o,
   input  logic [31:0]   mem_data_i
);

   // Highest word-aligned address that still lies inside the memory
   localparam logic [AW-1:0] MAX_ADDR_C = AW'(MEM_BYTES - 32'd4);

   state_t        state_r;
   state_t        state_nxt_s;
   logic          any_req_s;
   logic          grant_s;
   logic          grant_en_s;
   logic          last_grant_s;
   logic          sel_we_s;
   logic [AW-1:0] sel_addr_s;
   logic [31:0]   sel_wdata_s;
   logic          legal_s;

   // Latched transaction attributes for the ACCESS/RESP cycles
   logic          port_r;
   logic          we_r;
   logic          legal_r;

   // Registered outputs
   logic          ack0_r;
   logic          ack1_r;
   logic          err0_r;
   logic          err1_r;
   logic [31:0]   rdata_r;
   logic [31:0]   mem_addr_r;
   logic [31:0]   mem_data_r;
   logic          mem_read_r;
   logic          mem_write_r;

   assign any_req_s  = req0_i | req1_i;
   assign grant_en_s = (state_r == ST_IDLE) && any_req_s;

`ifdef DMEM_ARB_RR_EN
   logic last_grant_r;

   // Remember which port won the most recent grant for round-robin ties
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_r <= PORT1;
      end else if (grant_en_s) begin
         last_grant_r <= grant_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign last_grant_s = last_grant_r;
`else
   // Pretending port 1 was always last makes port 0 win every tie
   assign last_grant_s = PORT1;
`endif

   dmem_arb_pick u_pick (
      .req0_i       (req0_i),
      .req1_i       (req1_i),
      .last_grant_i (last_grant_s),
      .grant_o      (grant_s)
   );

   // Route the winning port's fields to the shared request path
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = '0;
      sel_wdata_s = 32'd0;
      if (grant_s == PORT1) begin
         sel_we_s    = we1_i;
         sel_addr_s  = addr1_i;
         sel_wdata_s = wdata1_i;
      end else begin
         sel_we_s    = we0_i;
         sel_addr_s  = addr0_i;
         sel_wdata_s = wdata0_i;
      end
   end

   // Word-aligned and fully inside the memory
   assign legal_s = (sel_addr_s[1:0] == 2'b00) && (sel_addr_s <= MAX_ADDR_C);

   // Next-state logic: one cycle each in ACCESS and RESP
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: state_nxt_s = ST_RESP;
         ST_RESP:   state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latch the winner's port, direction and legality at grant time
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         port_r  <= PORT0;
         we_r    <= 1'b0;
         legal_r <= 1'b0;
      end else if (grant_en_s) begin
         port_r  <= grant_s;
         we_r    <= sel_we_s;
         legal_r <= legal_s;
      end else begin
         port_r  <= port_r;
         we_r    <= we_r;
         legal_r <= legal_r;
      end
   end

   // Memory interface: strobes live for exactly the ACCESS cycle, address
   // and data hold their last values in between. Async reset drops the
   // strobes at once, so an interrupted store never reaches the memory.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= 32'd0;
         mem_data_r  <= 32'd0;
      end else if (grant_en_s) begin
         mem_read_r  <= legal_s && !sel_we_s;
         mem_write_r <= legal_s && sel_we_s;
         mem_addr_r  <= 32'(sel_addr_s);
         if (legal_s && sel_we_s) begin
            mem_data_r <= sel_wdata_s;
         end else begin
            mem_data_r <= mem_data_r;
         end
      end else begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= mem_addr_r;
         mem_data_r  <= mem_data_r;
      end
   end

   // Response: capture load data at the end of ACCESS, pulse ack in RESP
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         err0_r  <= 1'b0;
         err1_r  <= 1'b0;
         rdata_r <= 32'd0;
      end else if (state_r == ST_ACCESS) begin
         ack0_r <= (port_r == PORT0);
         ack1_r <= (port_r == PORT1);
         err0_r <= (port_r == PORT0) && !legal_r;
         err1_r <= (port_r == PORT1) && !legal_r;
         if (legal_r && !we_r) begin
            rdata_r <= mem_data_i;
         end else begin
            rdata_r <= 32'd0;
         end
      end else begin
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         err0_r  <= 1'b0;
         err1_r  <= 1'b0;
         rdata_r <= rdata_r;
      end
   end

   assign ack0_o      = ack0_r;
   assign ack1_o      = ack1_r;
   assign err0_o      = err0_r;
   assign err1_o      = err1_r;
   assign rdata_o     = rdata_r;
   assign mem_addr_o  = mem_addr_r;
   assign mem_data_o  = mem_data_r;
   assign mem_read_o  = mem_read_r;
   assign mem_write_o = mem_write_r;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a small
// transaction-level model and directed scenarios.
module tb_dmem_arbiter;

   localparam int MEM_BYTES_TB = 32;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req0_i = 1'b0, req1_i = 1'b0;
   logic        we0_i = 1'b0, we1_i = 1'b0;
   logic [31:0] addr0_i = 32'd0, addr1_i = 32'd0;
   logic [31:0] wdata0_i = 32'd0, wdata1_i = 32'd0;
   logic        ack0_o, ack1_o, err0_o, err1_o;
   logic [31:0] rdata_o, mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_read_o, mem_write_o;

   int checks = 0;
   int failures = 0;

   dmem_arbiter #(.MEM_BYTES(32), .AW(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .req1_i(req1_i),
      .we0_i(we0_i), .we1_i(we1_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i),
      .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .ack0_o(ack0_o), .ack1_o(ack1_o),
      .err0_o(err0_o), .err1_o(err1_o),
      .rdata_o(rdata_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Bench memory: combinational read, posedge write
   logic [31:0] mem [0:7] = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                              32'hA0000004, 32'hA0000005, 32'hA0000006, 32'hA0000007};
   assign mem_data_i = mem[mem_addr_o[4:2]];
   always @(posedge clk_i) begin
      if (mem_write_o) mem[mem_addr_o[4:2]] <= mem_data_o;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      bit          rd, wr, ack0, ack1, err, load;
      logic [31:0] addr, wdata, rdata;
   } exp_t;

   function automatic exp_t exp_zero();
      exp_t z;
      z.rd = 0; z.wr = 0; z.ack0 = 0; z.ack1 = 0; z.err = 0; z.load = 0;
      z.addr = 32'd0; z.wdata = 32'd0; z.rdata = 32'd0;
      return z;
   endfunction

   exp_t        exp_q [int];      // expectations keyed by clock interval
   int          edge_cnt = 0;     // interval index: number of posedges seen
   logic [31:0] model_mem [0:7];

   // Rules: a request is taken when the arbiter has been free for 3 cycles
   // since the last grant; strobe in the following cycle, ack one later.
   initial begin
      int          free_edge;
      bit          last_g;
      bit          pend_wr;
      int          pend_edge;
      int          pend_idx;
      logic [31:0] pend_data;
      bit          w, we, legal;
      logic [31:0] a, wd;
      exp_t        s, r;
      int          ks[$];
      for (int i = 0; i < 8; i++) model_mem[i] = 32'hA0000000 + i;
      free_edge = 0; last_g = 1; pend_wr = 0;
      forever begin
         @(posedge clk_i);
         edge_cnt++;
         if (rst_i) begin
            ks = {};
            foreach (exp_q[k]) if (k >= edge_cnt) ks.push_back(k);
            foreach (ks[i]) exp_q.delete(ks[i]);
            pend_wr = 0; free_edge = 0; last_g = 1;
         end else begin
            if (pend_wr && pend_edge == edge_cnt) begin
               model_mem[pend_idx] = pend_data;
               pend_wr = 0;
            end
            if (edge_cnt >= free_edge && (req0_i || req1_i)) begin
               if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
                  w = !last_g;
`else
                  w = 0;
`endif
               end else begin
                  w = req1_i;
               end
               we = w ? we1_i : we0_i;
               a  = w ? addr1_i : addr0_i;
               wd = w ? wdata1_i : wdata0_i;
               legal = (a % 4 == 0) && (a <= MEM_BYTES_TB - 4);
               s = exp_zero();
               s.rd = legal && !we; s.wr = legal && we; s.addr = a; s.wdata = wd;
               exp_q[edge_cnt] = s;
               r = exp_zero();
               r.ack0 = !w; r.ack1 = w; r.err = !legal; r.load = !we;
               r.rdata = (legal && !we) ? model_mem[a / 4] : 32'd0;
               exp_q[edge_cnt + 1] = r;
               if (legal && we) begin
                  pend_wr = 1; pend_edge = edge_cnt + 1; pend_idx = a / 4; pend_data = wd;
               end
               free_edge = edge_cnt + 3;
               last_g = w;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit rd_seen = 0;
   int wr_cnt = 0;
   int ack0_cnt = 0;
   int ack1_cnt = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (mem_read_o) rd_seen = 1;
         if (mem_write_o) wr_cnt++;
         if (ack0_o) ack0_cnt++;
         if (ack1_o) ack1_cnt++;
         if (rst_i) begin
            chk1("rst_ack0", ack0_o, 1'b0);
            chk1("rst_ack1", ack1_o, 1'b0);
            chk1("rst_err0", err0_o, 1'b0);
            chk1("rst_err1", err1_o, 1'b0);
            chk1("rst_read", mem_read_o, 1'b0);
            chk1("rst_write", mem_write_o, 1'b0);
            chk32("rst_rdata", rdata_o, 32'd0);
            chk32("rst_maddr", mem_addr_o, 32'd0);
            chk32("rst_mdata", mem_data_o, 32'd0);
         end else begin
            e = exp_q.exists(edge_cnt) ? exp_q[edge_cnt] : exp_zero();
            chk1("mem_read", mem_read_o, e.rd);
            chk1("mem_write", mem_write_o, e.wr);
            chk1("ack0", ack0_o, e.ack0);
            chk1("ack1", ack1_o, e.ack1);
            chk1("err0", err0_o, e.ack0 && e.err);
            chk1("err1", err1_o, e.ack1 && e.err);
            if (e.rd || e.wr) chk32("mem_addr", mem_addr_o, e.addr);
            if (e.wr) chk32("mem_data", mem_data_o, e.wdata);
            if ((e.ack0 || e.ack1) && e.load) chk32("rdata", rdata_o, e.rdata);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_ack(input bit port, output int at_edge,
                           output logic [31:0] rd, output logic er);
      logic got;
      got = 1'b0; at_edge = -1; rd = 32'd0; er = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk_i);
         if (port ? ack1_o : ack0_o) begin
            got = 1'b1; at_edge = edge_cnt; rd = rdata_o;
            er = port ? err1_o : err0_o;
         end
      end
      chk1("ack_seen", got, 1'b1);
   endtask

   task automatic access(input bit port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] rd, output logic er);
      int start, at;
      start = edge_cnt;
      if (port) begin
         req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wd;
      end else begin
         req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wd;
      end
      wait_ack(port, at, rd, er);
      lat = at - start;
      tick();
      if (port) req1_i = 1'b0; else req0_i = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      int          lat, e0, e1, cnt;
      logic [31:0] rd;
      logic        er, grant, got;
      logic [3:0]  exp_g;
      rst_i = 1'b1;
      #2;
      chk1("reset_ack0", ack0_o, 1'b0);
      chk32("reset_rdata", rdata_o, 32'd0);
      chk1("reset_write", mem_write_o, 1'b0);
      tick();
      tick();
      rst_i = 1'b0;

      // Port 0 store then load at address 8
      cnt = wr_cnt;
      access(0, 1'b1, 32'd8, 32'hDEADBEEF, lat, rd, er);
      chk32("store8_latency", lat, 32'd2);
      chk1("store8_err", er, 1'b0);
      chk32("store8_strobes", wr_cnt - cnt, 32'd1);
      access(0, 1'b0, 32'd8, 32'd0, lat, rd, er);
      chk32("load8_latency", lat, 32'd2);
      chk32("load8_rdata", rd, 32'hDEADBEEF);
      chk1("load8_err", er, 1'b0);

      // Boundary addresses 28 and 0, both ports
      access(1, 1'b1, 32'd28, 32'hCAFEF00D, lat, rd, er);
      access(0, 1'b0, 32'd28, 32'd0, lat, rd, er);
      chk32("load28_rdata", rd, 32'hCAFEF00D);
      access(1, 1'b0, 32'd0, 32'd0, lat, rd, er);
      chk32("load0_rdata", rd, 32'hA0000000);

      // Illegal port 1 loads, then an illegal store that must not land
      rd_seen = 0;
      access(1, 1'b0, 32'd6, 32'd0, lat, rd, er);
      chk1("ld6_err", er, 1'b1);
      chk32("ld6_rdata", rd, 32'd0);
      access(1, 1'b0, 32'd32, 32'd0, lat, rd, er);
      chk1("ld32_err", er, 1'b1);
      chk32("ld32_rdata", rd, 32'd0);
      chk1("illegal_no_read", rd_seen, 1'b0);
      cnt = wr_cnt;
      access(0, 1'b1, 32'd30, 32'h11111111, lat, rd, er);
      chk1("st30_err", er, 1'b1);
      chk32("st30_no_write", wr_cnt - cnt, 32'd0);

      // Port 1 arrives during port 0's ACCESS
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'd8;
      tick();
      req1_i = 1'b1; we1_i = 1'b0; addr1_i = 32'd0;
      wait_ack(0, e0, rd, er);
      chk32("late_ack0_rdata", rd, 32'hDEADBEEF);
      tick();
      req0_i = 1'b0;
      wait_ack(1, e1, rd, er);
      chk32("late_ack1_rdata", rd, 32'hA0000000);
      chk32("late_ack_gap", e1 - e0, 32'd3);
      tick();
      req1_i = 1'b0;

      // Simultaneous requests, four rounds after a fresh reset
      pulse_reset();
`ifdef DMEM_ARB_RR_EN
      exp_g = 4'b1010;
`else
      exp_g = 4'b0000;
`endif
      for (int i = 0; i < 4; i++) begin
         req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'd0;
         req1_i = 1'b1; we1_i = 1'b0; addr1_i = 32'd4;
         got = 1'b0; grant = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk_i);
            if (ack0_o || ack1_o) begin
               got = 1'b1; grant = ack1_o;
            end
         end
         chk1("tie_ack_seen", got, 1'b1);
         chk1("tie_grant", grant, exp_g[i]);
         tick();
         req0_i = 1'b0; req1_i = 1'b0;
      end

      // Reset in the middle of a store's ACCESS cycle
      cnt = ack0_cnt;
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 32'd4; wdata0_i = 32'h12345678;
      tick();
      #2;
      rst_i = 1'b1;
      req0_i = 1'b0;
      tick();
      tick();
      chk32("rst_mid_no_ack", ack0_cnt - cnt, 32'd0);
      chk32("rst_mid_mem4", mem[1], 32'hA0000001);
      rst_i = 1'b0;
      access(0, 1'b0, 32'd4, 32'd0, lat, rd, er);
      chk32("post_rst_latency", lat, 32'd2);
      chk32("post_rst_load4", rd, 32'hA0000001);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound in case a scenario stalls
   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_dmem_arbiter
